ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage LoongArch32 pipeline, directly downstream of the decode stage and upstream of the memory stage.
- Latches decoded operands through a valid/allowin pipeline register and computes the ALU result.
- Issues the data-SRAM request for ld.w/st.w.
- Exports its destination/result to decode for forwarding and load-use stall detection.

Parameters:
- RESET_PC, 32'h1bffffff, value of es_pc after reset.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ds_to_es_valid  in  1  decode holds a valid instruction for EX
- es_allowin  out  1  EX accepts a new instruction this cycle
- ds_pc  in  32  instruction PC
- ds_alu_op  in  12  one-hot ALU op: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui (bit 0..11)
- ds_alu_src1  in  32  ALU operand 1
- ds_alu_src2  in  32  ALU operand 2
- ds_rkd_value  in  32  store data
- ds_res_from_mem  in  1  load instruction
- ds_mem_we  in  1  store instruction
- ds_rf_we  in  1  writes GPR
- ds_rf_waddr  in  5  destination GPR
- ms_allowin  in  1  memory stage accepts
- es_to_ms_valid  out  1  valid instruction passed to MEM
- es_pc  out  32  PC of EX instruction
- es_rf_we  out  1  GPR write enable, gated by es_valid; used by MEM and by decode forwarding
- es_rf_waddr  out  5  destination GPR
- es_alu_result  out  32  ALU result
- es_res_from_mem  out  1  load flag, gated by es_valid
- data_sram_en  out  1  data SRAM request
- data_sram_we  out  4  byte write enables
- data_sram_addr  out  32  = es_alu_result
- data_sram_wdata  out  32  = latched rkd value

Behaviour:
- Reset: es_valid=0 and es_pc=RESET_PC. All other pipeline registers reset to 0, so es_rf_we=0, es_res_from_mem=0, data_sram_en=0 and data_sram_we=0.
- Handshake:
  - es_ready_go=1 (single-cycle ALU).
  - es_allowin = !es_valid | (es_ready_go & ms_allowin).
  - es_to_ms_valid = es_valid & es_ready_go.
- Valid register: when es_allowin, es_valid <= ds_to_es_valid on the clock edge.
- Payload registers (pc, alu_op, src1, src2, rkd, res_from_mem, mem_we, rf_we, rf_waddr) load only when es_allowin & ds_to_es_valid. Otherwise they hold, so a stalled instruction is stable.
- Latency: 1 cycle from decode handshake to es_alu_result valid. The result is combinational from the payload registers.
- ALU, 32-bit, operands treated as unsigned vectors unless stated:
  - add/sub wrap modulo 2^32.
  - slt is a signed compare; sltu is an unsigned compare. Both produce result 0 or 1.
  - sll/srl/sra shift src1 by src2[4:0]. sra is arithmetic.
  - lui produces result = src2.
  - alu_op all-zero produces result 0.
- Data SRAM:
  - data_sram_en = es_valid & ms_allowin & (res_from_mem | mem_we).
  - data_sram_we = {4{es_valid & ms_allowin & mem_we}}.
  - A stalled store writes exactly once: on the cycle it leaves EX.
- Forwarding outputs are gated by es_valid. A bubble must never match decode's conflict compare, even though stale payload remains in the registers.
- Backpressure (ms_allowin=0 while es_valid=1): es_allowin=0, all outputs hold, no SRAM request.
- Simultaneous leave and enter (es_valid & ms_allowin & ds_to_es_valid): the old instruction goes to MEM and the new one is latched in the same edge, so there is no bubble.
- Reset mid-operation dominates. es_valid clears next edge regardless of handshake, and any store in flight is not issued after reset assertion.
- No flush input: branches resolve in decode, and decode never sends a squashed instruction.

Decomposition:
- Shared package:
  - ALU op bit indices (ALU_ADD=0 … ALU_LUI=11) and ALU_OP_W=12, shared with decode.
  - Reset PC constant.
- One sub-module: alu (purely combinational, alu_op/src1/src2 -> result), instantiated once in ex_stage.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> es_valid=0, es_pc=32'h1bffffff, es_rf_we=0, data_sram_en=0, es_allowin=1.
- ALU sweep, one op per cycle, ms_allowin=1:
  - add 0xFFFFFFFF+1 -> 0
  - sub 0-1 -> 0xFFFFFFFF
  - slt 0x80000000,1 -> 1
  - sltu same operands -> 0
  - sra 0x80000000 by 31 -> 0xFFFFFFFF
  - srl same -> 1
  - nor 0,0 -> 0xFFFFFFFF
  - lui src2=0x12345000 -> 0x12345000
- Store under backpressure: st.w addr 0x100, data 0xDEADBEEF, ms_allowin=0 for 3 cycles then 1 -> data_sram_en/we stay 0 for the 3 stalled cycles; exactly one cycle with we=4'hF, addr=0x100, wdata=0xDEADBEEF; es_allowin=0 during the stall.
- Load forwarding: ld.w rf_waddr=5 -> es_res_from_mem=1, es_rf_we=1, es_rf_waddr=5 while in EX; next cycle with ds_to_es_valid=0 -> es_rf_we=0, es_res_from_mem=0.
- Back-to-back: three add instructions on consecutive cycles, ms_allowin=1 -> es_to_ms_valid=1 for 3 consecutive cycles, es_pc sequence matches input, no bubbles.
- Reset mid-stall: es_valid=1 holding a store with ms_allowin=0, assert resetn=0 -> next cycle es_valid=0, data_sram_en=0, and no write ever issued.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU op encoding, datapath width,
// and the EX pipeline-register payload layout.
package ex_stage_pkg;

  localparam int DATA_W   = 32;
  localparam int ALU_OP_W = 12;
  localparam int RF_AW    = 5;

  // One-hot ALU op bit positions, shared with decode
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam logic [DATA_W-1:0] RESET_PC_DEF = 32'h1bffffff;

  typedef struct packed {
    logic [DATA_W-1:0]   pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [DATA_W-1:0]   src1;
    logic [DATA_W-1:0]   src2;
    logic [DATA_W-1:0]   rkd;
    logic                res_from_mem;
    logic                mem_we;
    logic                rf_we;
    logic [RF_AW-1:0]    rf_waddr;
  } es_payload_t;

  // Reset image of the payload: everything zero except the PC
  function automatic es_payload_t payload_reset(input logic [DATA_W-1:0] pc);
    es_payload_t p;
    p    = '0;
    p.pc = pc;
    return p;
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational 32-bit ALU driven by a one-hot op vector; an all-zero op
// vector yields zero because every lane is masked by its op bit.
module ex_stage_alu
  import ex_stage_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]   src1,
  input  logic [DATA_W-1:0]   src2,
  output logic [DATA_W-1:0]   result
);

  logic signed [DATA_W-1:0] src1_s;
  logic signed [DATA_W-1:0] src2_s;
  logic        [4:0]        shamt;
  logic        [DATA_W-1:0] add_res;
  logic        [DATA_W-1:0] sub_res;
  logic                     slt_bit;
  logic                     sltu_bit;
  logic        [DATA_W-1:0] sll_res;
  logic        [DATA_W-1:0] srl_res;
  logic signed [DATA_W-1:0] sra_res;

  assign src1_s   = src1;
  assign src2_s   = src2;
  assign shamt    = src2[4:0];

  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_bit  = src1_s < src2_s;
  assign sltu_bit = src1 < src2;
  assign sll_res  = src1 << shamt;
  assign srl_res  = src1 >> shamt;
  assign sra_res  = src1_s >>> shamt;

  always_comb begin
    result = '0;
    result = result | ({DATA_W{alu_op[ALU_ADD]}}  & add_res);
    result = result | ({DATA_W{alu_op[ALU_SUB]}}  & sub_res);
    result = result | ({DATA_W{alu_op[ALU_SLT]}}  & {{(DATA_W-1){1'b0}}, slt_bit});
    result = result | ({DATA_W{alu_op[ALU_SLTU]}} & {{(DATA_W-1){1'b0}}, sltu_bit});
    result = result | ({DATA_W{alu_op[ALU_AND]}}  & (src1 & src2));
    result = result | ({DATA_W{alu_op[ALU_NOR]}}  & ~(src1 | src2));
    result = result | ({DATA_W{alu_op[ALU_OR]}}   & (src1 | src2));
    result = result | ({DATA_W{alu_op[ALU_XOR]}}  & (src1 ^ src2));
    result = result | ({DATA_W{alu_op[ALU_SLL]}}  & sll_res);
    result = result | ({DATA_W{alu_op[ALU_SRL]}}  & srl_res);
    result = result | ({DATA_W{alu_op[ALU_SRA]}}  & sra_res);
    result = result | ({DATA_W{alu_op[ALU_LUI]}}  & src2);
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: valid/allowin pipeline register between decode and memory,
// single-cycle ALU, data-SRAM request and forwarding outputs for decode.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        ds_to_es_valid,
  output logic        es_allowin,
  input  logic [31:0] ds_pc,
  input  logic [11:0] ds_alu_op,
  input  logic [31:0] ds_alu_src1,
  input  logic [31:0] ds_alu_src2,
  input  logic [31:0] ds_rkd_value,
  input  logic        ds_res_from_mem,
  input  logic        ds_mem_we,
  input  logic        ds_rf_we,
  input  logic [4:0]  ds_rf_waddr,

  input  logic        ms_allowin,
  output logic        es_to_ms_valid,
  output logic [31:0] es_pc,
  output logic        es_rf_we,
  output logic [4:0]  es_rf_waddr,
  output logic [31:0] es_alu_result,
  output logic        es_res_from_mem,

  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  logic        vld_p0;
  es_payload_t pl_in;
  es_payload_t pl_p0;
  logic        es_ready_go;
  logic        es_accept;
  logic        sram_go;

  assign es_ready_go    = 1'b1;
  assign es_allowin     = !vld_p0 || (es_ready_go && ms_allowin);
  assign es_to_ms_valid = vld_p0 && es_ready_go;
  assign es_accept      = es_allowin && ds_to_es_valid;

  always_comb begin
    pl_in              = '0;
    pl_in.pc           = ds_pc;
    pl_in.alu_op       = ds_alu_op;
    pl_in.src1         = ds_alu_src1;
    pl_in.src2         = ds_alu_src2;
    pl_in.rkd          = ds_rkd_value;
    pl_in.res_from_mem = ds_res_from_mem;
    pl_in.mem_we       = ds_mem_we;
    pl_in.rf_we        = ds_rf_we;
    pl_in.rf_waddr     = ds_rf_waddr;
  end

  // Stage p0: decode -> EX register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p0 <= 1'b0;
    end else if (es_allowin) begin
      vld_p0 <= ds_to_es_valid;
    end
  end

  // Payload holds while stalled so the request presented to SRAM is stable
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pl_p0 <= payload_reset(RESET_PC);
    end else if (es_accept) begin
      pl_p0 <= pl_in;
    end
  end

  ex_stage_alu u_alu (
    .alu_op (pl_p0.alu_op),
    .src1   (pl_p0.src1),
    .src2   (pl_p0.src2),
    .result (es_alu_result)
  );

  assign es_pc           = pl_p0.pc;
  assign es_rf_waddr     = pl_p0.rf_waddr;
  // Gated by valid so a bubble's stale payload never matches in decode
  assign es_rf_we        = vld_p0 && pl_p0.rf_we;
  assign es_res_from_mem = vld_p0 && pl_p0.res_from_mem;

  // The request fires only on the cycle the instruction leaves EX, so a
  // stalled store writes once; reset assertion suppresses it immediately.
  assign sram_go         = resetn && vld_p0 && ms_allowin;
  assign data_sram_en    = sram_go && (pl_p0.res_from_mem || pl_p0.mem_we);
  assign data_sram_we    = {4{sram_go && pl_p0.mem_we}};
  assign data_sram_addr  = es_alu_result;
  assign data_sram_wdata = pl_p0.rkd;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: reset, ALU sweep, stalled store,
// load forwarding, back-to-back flow and reset during a stall.
module tb_ex_stage;

  logic        clk;
  logic        resetn;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [31:0] ds_pc;
  logic [11:0] ds_alu_op;
  logic [31:0] ds_alu_src1;
  logic [31:0] ds_alu_src2;
  logic [31:0] ds_rkd_value;
  logic        ds_res_from_mem;
  logic        ds_mem_we;
  logic        ds_rf_we;
  logic [4:0]  ds_rf_waddr;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic        es_rf_we;
  logic [4:0]  es_rf_waddr;
  logic [31:0] es_alu_result;
  logic        es_res_from_mem;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;

  ex_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .ds_to_es_valid  (ds_to_es_valid),
    .es_allowin      (es_allowin),
    .ds_pc           (ds_pc),
    .ds_alu_op       (ds_alu_op),
    .ds_alu_src1     (ds_alu_src1),
    .ds_alu_src2     (ds_alu_src2),
    .ds_rkd_value    (ds_rkd_value),
    .ds_res_from_mem (ds_res_from_mem),
    .ds_mem_we       (ds_mem_we),
    .ds_rf_we        (ds_rf_we),
    .ds_rf_waddr     (ds_rf_waddr),
    .ms_allowin      (ms_allowin),
    .es_to_ms_valid  (es_to_ms_valid),
    .es_pc           (es_pc),
    .es_rf_we        (es_rf_we),
    .es_rf_waddr     (es_rf_waddr),
    .es_alu_result   (es_alu_result),
    .es_res_from_mem (es_res_from_mem),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles carrying a store write, sampled mid-cycle
  always @(negedge clk) begin
    if (data_sram_we != 4'h0) wr_cnt <= wr_cnt + 1;
  end

  // ALU vectors: op bit index (-1 = no op), src1, src2, expected result
  int          alu_op_t  [13] = '{0, 1, 2, 3, 10, 9, 5, 11, 4, 6, 7, 8, -1};
  logic [31:0] alu_a_t   [13] = '{32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h80000000,
                                  32'h80000000, 32'h80000000, 32'h0, 32'h0,
                                  32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                  32'h1, 32'hDEADBEEF};
  logic [31:0] alu_b_t   [13] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'd31, 32'd31,
                                  32'h0, 32'h12345000, 32'hFF00FF00, 32'h0F0F0F0F,
                                  32'hFF00FF00, 32'd31, 32'h12345678};
  logic [31:0] alu_exp_t [13] = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF,
                                  32'h1, 32'hFFFFFFFF, 32'h12345000, 32'hF000F000,
                                  32'hFFFFFFFF, 32'h0FF00FF0, 32'h80000000, 32'h0};

  task automatic drive_ins(input logic [31:0] pc, input int op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] rkd, input logic ld,
                           input logic st, input logic we, input logic [4:0] wa);
    ds_to_es_valid  = 1'b1;
    ds_pc           = pc;
    ds_alu_op       = '0;
    if (op >= 0) ds_alu_op[op] = 1'b1;
    ds_alu_src1     = a;
    ds_alu_src2     = b;
    ds_rkd_value    = rkd;
    ds_res_from_mem = ld;
    ds_mem_we       = st;
    ds_rf_we        = we;
    ds_rf_waddr     = wa;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", es_to_ms_valid); end
    checks++; if (es_pc !== 32'h1bffffff) begin errors++; $display("FAIL rst_pc got %h want 1bffffff", es_pc); end
    checks++; if (es_rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got %b want 0", es_rf_we); end
    checks++; if (es_res_from_mem !== 1'b0) begin errors++; $display("FAIL rst_ld got %b want 0", es_res_from_mem); end
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL rst_sram_en got %b want 0", data_sram_en); end
    checks++; if (data_sram_we !== 4'h0) begin errors++; $display("FAIL rst_sram_we got %h want 0", data_sram_we); end
    checks++; if (es_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin got %b want 1", es_allowin); end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    ms_allowin = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive_ins(32'h1c000000 + 32'(i * 4), alu_op_t[i], alu_a_t[i], alu_b_t[i],
                32'h0, 1'b0, 1'b0, 1'b1, 5'(i));
      @(posedge clk); #1;
      checks++; if (es_alu_result !== alu_exp_t[i]) begin errors++; $display("FAIL alu_%0d got %h want %h", i, es_alu_result, alu_exp_t[i]); end
      checks++; if (es_pc !== 32'h1c000000 + 32'(i * 4)) begin errors++; $display("FAIL alu_pc_%0d got %h want %h", i, es_pc, 32'h1c000000 + 32'(i * 4)); end
    end
    ds_to_es_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL alu_drain got %b want 0", es_to_ms_valid); end
  endtask

  task automatic test_store_stall();
    wr_cnt = 0;
    ms_allowin = 1'b0;
    drive_ins(32'h1c000100, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd0);
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL st_stall_en_%0d got %b want 0", c, data_sram_en); end
      checks++; if (data_sram_we !== 4'h0) begin errors++; $display("FAIL st_stall_we_%0d got %h want 0", c, data_sram_we); end
      checks++; if (es_allowin !== 1'b0) begin errors++; $display("FAIL st_stall_allowin_%0d got %b want 0", c, es_allowin); end
      checks++; if (es_pc !== 32'h1c000100) begin errors++; $display("FAIL st_stall_pc_%0d got %h want 1c000100", c, es_pc); end
      if (c < 2) begin @(posedge clk); #1; end
    end
    ms_allowin = 1'b1;
    #1;
    checks++; if (data_sram_en !== 1'b1) begin errors++; $display("FAIL st_go_en got %b want 1", data_sram_en); end
    checks++; if (data_sram_we !== 4'hF) begin errors++; $display("FAIL st_go_we got %h want f", data_sram_we); end
    checks++; if (data_sram_addr !== 32'h100) begin errors++; $display("FAIL st_go_addr got %h want 100", data_sram_addr); end
    checks++; if (data_sram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL st_go_wdata got %h want deadbeef", data_sram_wdata); end
    checks++; if (es_allowin !== 1'b1) begin errors++; $display("FAIL st_go_allowin got %b want 1", es_allowin); end
    @(posedge clk); #1;
    checks++; if (data_sram_we !== 4'h0) begin errors++; $display("FAIL st_after_we got %h want 0", data_sram_we); end
    @(posedge clk); #1;
    checks++; if (wr_cnt !== 1) begin errors++; $display("FAIL st_write_count got %0d want 1", wr_cnt); end
  endtask

  task automatic test_load_fwd();
    ms_allowin = 1'b1;
    drive_ins(32'h1c000200, 0, 32'h200, 32'h4, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5);
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    checks++; if (es_res_from_mem !== 1'b1) begin errors++; $display("FAIL ld_flag got %b want 1", es_res_from_mem); end
    checks++; if (es_rf_we !== 1'b1) begin errors++; $display("FAIL ld_rf_we got %b want 1", es_rf_we); end
    checks++; if (es_rf_waddr !== 5'd5) begin errors++; $display("FAIL ld_waddr got %0d want 5", es_rf_waddr); end
    checks++; if (data_sram_en !== 1'b1) begin errors++; $display("FAIL ld_sram_en got %b want 1", data_sram_en); end
    checks++; if (data_sram_we !== 4'h0) begin errors++; $display("FAIL ld_sram_we got %h want 0", data_sram_we); end
    checks++; if (data_sram_addr !== 32'h204) begin errors++; $display("FAIL ld_addr got %h want 204", data_sram_addr); end
    @(posedge clk); #1;
    checks++; if (es_rf_we !== 1'b0) begin errors++; $display("FAIL ld_bubble_rf_we got %b want 0", es_rf_we); end
    checks++; if (es_res_from_mem !== 1'b0) begin errors++; $display("FAIL ld_bubble_flag got %b want 0", es_res_from_mem); end
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL ld_bubble_en got %b want 0", data_sram_en); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    pcs[0] = 32'h1c000300; pcs[1] = 32'h1c000304; pcs[2] = 32'h1c000308;
    ms_allowin = 1'b1;
    drive_ins(pcs[0], 0, 32'd10, 32'd1, 32'h0, 1'b0, 1'b0, 1'b1, 5'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++; if (es_to_ms_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_%0d got %b want 1", k, es_to_ms_valid); end
      checks++; if (es_pc !== pcs[k]) begin errors++; $display("FAIL b2b_pc_%0d got %h want %h", k, es_pc, pcs[k]); end
      checks++; if (es_alu_result !== 32'(11 + k)) begin errors++; $display("FAIL b2b_res_%0d got %h want %h", k, es_alu_result, 32'(11 + k)); end
      checks++; if (es_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin_%0d got %b want 1", k, es_allowin); end
      if (k < 2) drive_ins(pcs[k + 1], 0, 32'(11 + k), 32'd1, 32'h0, 1'b0, 1'b0, 1'b1, 5'(k + 2));
      else ds_to_es_valid = 1'b0;
    end
    @(posedge clk); #1;
    checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", es_to_ms_valid); end
  endtask

  task automatic test_reset_mid_stall();
    wr_cnt = 0;
    ms_allowin = 1'b0;
    drive_ins(32'h1c000400, 0, 32'h300, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 5'd0);
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
    checks++; if (es_to_ms_valid !== 1'b1) begin errors++; $display("FAIL rms_held got %b want 1", es_to_ms_valid); end
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL rms_held_en got %b want 0", data_sram_en); end
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL rms_valid got %b want 0", es_to_ms_valid); end
    checks++; if (data_sram_en !== 1'b0) begin errors++; $display("FAIL rms_en got %b want 0", data_sram_en); end
    checks++; if (es_pc !== 32'h1bffffff) begin errors++; $display("FAIL rms_pc got %h want 1bffffff", es_pc); end
    resetn = 1'b1;
    ms_allowin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (data_sram_we !== 4'h0) begin errors++; $display("FAIL rms_after_we got %h want 0", data_sram_we); end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL rms_write_count got %0d want 0", wr_cnt); end
  endtask

  initial begin
    resetn          = 1'b0;
    ds_to_es_valid  = 1'b0;
    ds_pc           = '0;
    ds_alu_op       = '0;
    ds_alu_src1     = '0;
    ds_alu_src2     = '0;
    ds_rkd_value    = '0;
    ds_res_from_mem = 1'b0;
    ds_mem_we       = 1'b0;
    ds_rf_we        = 1'b0;
    ds_rf_waddr     = '0;
    ms_allowin      = 1'b1;

    test_reset();
    test_alu();
    test_store_stall();
    test_load_fwd();
    test_back_to_back();
    test_reset_mid_stall();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
